mul_div_ctrl: RTL
=================

MUL_DIV_CTRL -- requirements
Module: mul_div_ctrl

Interface
REQ-001 The block SHALL have one clock and one reset; reset is synchronous and active-high.
REQ-002 Parameter: WIDTH, 32, operand and result word width; all behaviour below is stated for WIDTH=32.
REQ-003 Port: clock  input  1  rising-edge clock for all state.
REQ-004 Port: reset  input  1  synchronous active-high reset.
REQ-005 Port: start  input  1  request to begin an operation; sampled only in IDLE.
REQ-006 Port: op  input  2  00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU.
REQ-007 Port: a  input  32  multiplicand or dividend.
REQ-008 Port: b  input  32  multiplier or divisor.
REQ-009 Port: busy  output  1  high while an operation is in RUN or FIX.
REQ-010 Port: done  output  1  one-cycle pulse; hi and lo are valid when it is high.
REQ-011 Port: hi  output  32  MULT/MULTU: product[63:32]; DIV/DIVU: remainder.
REQ-012 Port: lo  output  32  MULT/MULTU: product[31:0]; DIV/DIVU: quotient.
REQ-013 Port: div_by_zero  output  1  set with done when a DIV/DIVU had b==0; held until the next start is accepted.

Function
REQ-014 FSM states SHALL be IDLE, RUN, FIX and DONE, with these transitions:
- IDLE->RUN on start=1.
- RUN->FIX after exactly 32 RUN cycles.
- FIX->DONE unconditionally.
- DONE->IDLE unconditionally.
REQ-015 At start acceptance (edge k) the block SHALL latch:
- op;
- for signed ops, the operand magnitudes plus the sign of a and the sign of a XOR b;
- for unsigned ops, the raw operands.
REQ-016 Changes on a, b or op after edge k SHALL have no effect on the running operation.
REQ-017 RUN SHALL perform one radix-2 step per cycle, tracked by a 5-bit iteration counter loaded with 31 at edge k:
- multiply: shift-add into a 64-bit accumulator;
- divide: restoring shift-subtract.
REQ-018 hi, lo and div_by_zero SHALL update only at the FIX->DONE edge (edge k+33); done SHALL be high for exactly the cycle following that edge.
REQ-019 busy SHALL be 1 from edge k to edge k+33, and 0 in IDLE and DONE.
REQ-020 start SHALL be ignored in RUN, FIX and DONE; no queuing.
REQ-021 Minimum start-to-start spacing is therefore 35 cycles.
REQ-022 Signed multiply: {hi,lo} SHALL be the exact 64-bit two's-complement product, produced by negating the 64-bit magnitude result when the signs differ.
REQ-023 Signed divide: the quotient SHALL truncate toward zero and the remainder SHALL take the sign of the dividend.
REQ-024 Signed divide 0x80000000 / 0xFFFFFFFF SHALL give lo=0x80000000, hi=0x00000000, with no flag.
REQ-025 Divide with b==0 SHALL give div_by_zero=1, lo=0xFFFFFFFF and hi=a (as latched), with unchanged 34-cycle latency and no sign fix-up.
REQ-026 For multiplies and non-zero divides, div_by_zero SHALL be 0 at done.
REQ-027 Between operations, hi and lo SHALL hold their last values.

Reset
REQ-028 When reset=1 at an edge, the block SHALL go to IDLE with busy=0, done=0, hi=0, lo=0, div_by_zero=0 and counter=0, regardless of state; this includes mid-RUN.
REQ-029 reset SHALL take priority over start in the same cycle.
REQ-030 After reset deasserts, the first start SHALL be accepted normally.

Structure
REQ-031 A shared package mul_div_pkg SHALL hold:
- the op encodings MD_MULT, MD_MULTU, MD_DIV and MD_DIVU;
- the state enumeration;
- the constant MD_ITER=32.
REQ-032 One sub-module, md_step_32, SHALL implement a single combinational shift-add/shift-subtract iteration step; the FSM, counter, sign handling and output registers SHALL live in mul_div_ctrl.
REQ-033 No multiply or divide operator SHALL be inferred anywhere.

Verification
REQ-034 MULT a=0xFFFFFFFD (-3), b=0x00000007, start at edge k -> done high only in cycle after edge k+33; hi=0xFFFFFFFF, lo=0xFFFFFFEB; busy high 33 cycles.
REQ-035 MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
REQ-036 DIV a=0xFFFFFFF9 (-7), b=0x00000002 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-037 DIVU a=5, b=0 -> div_by_zero=1, lo=0xFFFFFFFF, hi=0x00000005 at done; next accepted start -> div_by_zero=0.
REQ-038 Start MULTU 3*4, then change a/b and pulse start during RUN -> result hi=0, lo=12, single done pulse.
REQ-039 Start MULTU 3*4, assert reset at RUN iteration 10 -> next cycle busy=0, done=0, hi=lo=0, and no done pulse follows.

Source files
------------

// File: rtl/mul_div_pkg.sv
// Shared definitions for the iterative multiply/divide controller:
// op encodings, FSM state type and the iteration count.
package mul_div_pkg;

  localparam logic [1:0] MD_MULT  = 2'b00;
  localparam logic [1:0] MD_MULTU = 2'b01;
  localparam logic [1:0] MD_DIV   = 2'b10;
  localparam logic [1:0] MD_DIVU  = 2'b11;

  localparam int MD_ITER = 32;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_FIX,
    ST_DONE
  } md_state_t;

endpackage

// File: rtl/md_step_32.sv
// One radix-2 iteration: right-shift shift-add for multiply, left-shift
// restoring shift-subtract for divide, over a double-width accumulator.
module md_step_32 #(
  parameter int WIDTH = 32
) (
  input  logic               is_div,
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   operand,
  output logic [2*WIDTH-1:0] acc_next
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // diff[WIDTH] is the borrow: the remainder stays below the divisor, so a
  // successful subtract always leaves the top bit clear.
  always_comb begin
    sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, operand};
    shifted  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    diff     = shifted - {1'b0, operand};
    acc_next = acc;
    if (is_div) begin
      if (!diff[WIDTH])
        acc_next = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      else
        acc_next = {shifted[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end else if (acc[0]) begin
      acc_next = {sum, acc[WIDTH-1:1]};
    end else begin
      acc_next = {1'b0, acc[2*WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/mul_div_ctrl.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit: works on operand magnitudes for
// WIDTH cycles, then applies the sign fix-up and registers hi/lo.
module mul_div_ctrl
  import mul_div_pkg::*;
#(
  parameter int WIDTH = MD_ITER
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH);

  md_state_t state, next_state;

  logic [CW-1:0]      count;
  logic [1:0]         op_q;
  logic               sign_a;
  logic               sign_x;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_step;
  logic [WIDTH-1:0]   operand;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic               start_accept;

  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   hi_fix;
  logic [WIDTH-1:0]   lo_fix;
  logic               dz_fix;

  md_step_32 #(.WIDTH(WIDTH)) u_step (
    .is_div   (op_q[1]),
    .acc      (acc),
    .operand  (operand),
    .acc_next (acc_step)
  );

  assign start_accept = (state == ST_IDLE) && start;
  assign a_mag = (!op[0] && a[WIDTH-1]) ? -a : a;
  assign b_mag = (!op[0] && b[WIDTH-1]) ? -b : b;
  assign busy  = (state == ST_RUN) || (state == ST_FIX);
  assign done  = (state == ST_DONE);

  always_ff @(posedge clock) begin
    if (reset) state <= ST_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: if (start) next_state = ST_RUN;
      ST_RUN:  if (count == '0) next_state = ST_FIX;
      ST_FIX:  next_state = ST_DONE;
      ST_DONE: next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  // Divide by zero falls out of the restoring loop as quotient all-ones and
  // remainder equal to the latched dividend, so it only skips the sign fix-up.
  always_comb begin
    prod = acc;
    if (!op_q[0] && sign_x) prod = -acc;
    quo = acc[WIDTH-1:0];
    rem = acc[2*WIDTH-1:WIDTH];
    if (!op_q[0]) begin
      if (sign_x) quo = -acc[WIDTH-1:0];
      if (sign_a) rem = -acc[2*WIDTH-1:WIDTH];
    end
    dz_fix = op_q[1] && (operand == '0);
    hi_fix = prod[2*WIDTH-1:WIDTH];
    lo_fix = prod[WIDTH-1:0];
    if (op_q[1]) begin
      if (dz_fix) begin
        hi_fix = acc[2*WIDTH-1:WIDTH];
        lo_fix = '1;
      end else begin
        hi_fix = rem;
        lo_fix = quo;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count       <= '0;
      op_q        <= MD_MULT;
      sign_a      <= 1'b0;
      sign_x      <= 1'b0;
      acc         <= '0;
      operand     <= '0;
      hi          <= '0;
      lo          <= '0;
      div_by_zero <= 1'b0;
    end else if (start_accept) begin
      count       <= CW'(WIDTH - 1);
      op_q        <= op;
      sign_a      <= !op[0] && a[WIDTH-1];
      sign_x      <= !op[0] && (a[WIDTH-1] ^ b[WIDTH-1]);
      acc         <= op[1] ? {{WIDTH{1'b0}}, a_mag} : {{WIDTH{1'b0}}, b_mag};
      operand     <= op[1] ? b_mag : a_mag;
      div_by_zero <= 1'b0;
    end else if (state == ST_RUN) begin
      acc   <= acc_step;
      count <= count - 1'b1;
    end else if (state == ST_FIX) begin
      hi          <= hi_fix;
      lo          <= lo_fix;
      div_by_zero <= dz_fix;
    end
  end

endmodule
